// File: rtl/lif_pkg.sv
// rtl/lif_pkg.sv - shared types and constants for the LIF sweep scheduler
package lif_pkg;

    localparam int LIF_W  = 8;
    localparam int BETA_W = 3;
    localparam int REFR_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } lif_state_e;

    typedef struct packed {
        logic [LIF_W-1:0]  thresh;
        logic [BETA_W-1:0] beta;
        logic [REFR_W-1:0] refr;
    } lif_cfg_t;

endpackage

// File: rtl/lif_scheduler_if.sv
// rtl/lif_scheduler_if.sv - current-load and config write bus of the LIF scheduler
interface lif_scheduler_if #(
    parameter int AW = 2,
    parameter int W  = 8
);
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic [W-1:0]  ld_data;
    logic          cfg_we;
    logic [W-1:0]  cfg_thresh;
    logic [2:0]    cfg_beta;
    logic [3:0]    cfg_refr;

    modport master (
        output ld_valid, ld_addr, ld_data, cfg_we, cfg_thresh, cfg_beta, cfg_refr
    );

    modport slave (
        input ld_valid, ld_addr, ld_data, cfg_we, cfg_thresh, cfg_beta, cfg_refr
    );
endinterface

// File: rtl/lif_update.sv
// rtl/lif_update.sv - combinational single-neuron leak/integrate/fire step
module lif_update #(
    parameter int W = 8
) (
    input  logic [W-1:0] s,
    input  logic [W-1:0] cur,
    input  logic [3:0]   refr_cnt,
    input  logic [W-1:0] thresh,
    input  logic [2:0]   beta,
    input  logic [3:0]   refr,
    output logic [W-1:0] s_next,
    output logic [3:0]   refr_next,
    output logic         spike
);
    logic [W-1:0] leaked;
    logic [W:0]   sum;

    always_comb begin
        leaked = (beta == 3'd0) ? '0 : (s - (s >> beta));
        sum    = {1'b0, leaked} + {1'b0, cur};
    end

    always_comb begin
        s_next    = '0;
        refr_next = refr_cnt;
        spike     = 1'b0;
        if (refr_cnt != 4'd0) begin
            refr_next = refr_cnt - 4'd1;
        end else if (sum >= {1'b0, thresh}) begin
            spike     = 1'b1;
            refr_next = refr;
        end else begin
            // sum < thresh <= 2^W-1, so the top bit is known to be zero here
            s_next = sum[W-1:0];
        end
    end
endmodule

// File: rtl/lif_scheduler.sv
// rtl/lif_scheduler.sv - sweeps one shared LIF datapath across all virtual neurons per tick
module lif_scheduler
    import lif_pkg::*;
#(
    parameter int N_NEURONS      = 4,
    parameter int W              = 8,
    parameter int THRESH_DEFAULT = 200,
    parameter int BETA_DEFAULT   = 2,
    parameter int REFR_DEFAULT   = 2,
    localparam int AW            = $clog2(N_NEURONS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    lif_scheduler_if.slave       bus,
    input  logic [AW-1:0]        mon_sel,
    output logic [W-1:0]         mon_state,
    output logic [N_NEURONS-1:0] spikes,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun
);
    localparam lif_cfg_t CFG_RESET = '{
        thresh: LIF_W'(THRESH_DEFAULT),
        beta:   BETA_W'(BETA_DEFAULT),
        refr:   REFR_W'(REFR_DEFAULT)
    };

    lif_state_e state_q, state_d;
    logic [AW-1:0] idx_q;
    logic [W-1:0]  mem_q  [N_NEURONS];
    logic [W-1:0]  cur_q  [N_NEURONS];
    logic [3:0]    refr_q [N_NEURONS];
    logic [N_NEURONS-1:0] spikes_q;
    logic          pending_q, overrun_q;
    lif_cfg_t      shadow_q, active_q;

    logic          start, last;
    logic [W-1:0]  s_next;
    logic [3:0]    refr_next;
    logic          spike;

    assign start = (state_q == IDLE) && (tick || pending_q);
    assign last  = (idx_q == AW'(N_NEURONS - 1));

    lif_update #(.W(W)) u_update (
        .s         (mem_q[idx_q]),
        .cur       (cur_q[idx_q]),
        .refr_cnt  (refr_q[idx_q]),
        .thresh    (W'(active_q.thresh)),
        .beta      (active_q.beta),
        .refr      (active_q.refr),
        .s_next    (s_next),
        .refr_next (refr_next),
        .spike     (spike)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN) || (state_q == DONE);
        done = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q     <= '0;
            spikes_q  <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            shadow_q  <= CFG_RESET;
            active_q  <= CFG_RESET;
            for (int k = 0; k < N_NEURONS; k++) begin
                mem_q[k]  <= '0;
                cur_q[k]  <= '0;
                refr_q[k] <= '0;
            end
        end else begin
            if (bus.ld_valid) cur_q[bus.ld_addr] <= bus.ld_data;
            if (bus.cfg_we) begin
                shadow_q <= '{thresh: LIF_W'(bus.cfg_thresh), beta: bus.cfg_beta, refr: bus.cfg_refr};
            end
            if (start) begin
                idx_q     <= '0;
                active_q  <= shadow_q;
                pending_q <= 1'b0;
            end else if (tick && busy) begin
                // one tick may wait; a second one while waiting is lost
                if (pending_q) overrun_q <= 1'b1;
                else           pending_q <= 1'b1;
            end
            if (state_q == RUN) begin
                mem_q[idx_q]    <= s_next;
                refr_q[idx_q]   <= refr_next;
                spikes_q[idx_q] <= spike;
                idx_q           <= idx_q + AW'(1);
            end
        end
    end

    assign mon_state = mem_q[mon_sel];
    assign spikes    = spikes_q;
    assign overrun   = overrun_q;
endmodule

// File: tb/tb_lif_scheduler.sv
// tb/tb_lif_scheduler.sv - scoreboard bench for lif_scheduler
module tb_lif_scheduler;
    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n, tick;
    logic [1:0] mon_sel;
    logic [7:0] mon_state;
    logic [3:0] spikes;
    logic       busy, done, overrun;

    always #5 clk = ~clk;

    lif_scheduler_if #(.AW(2), .W(8)) bus ();

    lif_scheduler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .bus       (bus.slave),
        .mon_sel   (mon_sel),
        .mon_state (mon_state),
        .spikes    (spikes),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun)
    );

    typedef struct {
        int s;
        bit sp;
    } exp_t;

    exp_t exp_q[$];
    int   m_s[N], m_cur[N], m_refr[N];
    logic [3:0] m_spk;
    int   sh_th, sh_beta, sh_refr, ac_th, ac_beta, ac_refr;
    bit   m_pending, m_overrun;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_s[k] = 0; m_cur[k] = 0; m_refr[k] = 0;
        end
        m_spk = '0;
        sh_th = 200; sh_beta = 2; sh_refr = 2;
        ac_th = 200; ac_beta = 2; ac_refr = 2;
        m_pending = 0; m_overrun = 0;
    endtask

    function automatic void model_update(input int k);
        exp_t e;
        int leaked, sum;
        if (m_refr[k] != 0) begin
            m_s[k] = 0; m_refr[k]--; m_spk[k] = 1'b0;
        end else begin
            leaked = (ac_beta == 0) ? 0 : m_s[k] - (m_s[k] >> ac_beta);
            sum = leaked + m_cur[k];
            if (sum >= ac_th) begin
                m_spk[k] = 1'b1; m_s[k] = 0; m_refr[k] = ac_refr;
            end else begin
                m_s[k] = sum; m_spk[k] = 1'b0;
            end
        end
        e.s = m_s[k];
        e.sp = m_spk[k];
        exp_q.push_back(e);
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic idle_load(input int a, input int d);
        bus.ld_valid = 1'b1; bus.ld_addr = 2'(a); bus.ld_data = 8'(d);
        @(posedge clk); #1;
        bus.ld_valid = 1'b0;
        m_cur[a] = d;
    endtask

    task automatic idle_cfg(input int th, input int b, input int r);
        bus.cfg_we = 1'b1; bus.cfg_thresh = 8'(th); bus.cfg_beta = 3'(b); bus.cfg_refr = 4'(r);
        @(posedge clk); #1;
        bus.cfg_we = 1'b0;
        sh_th = th; sh_beta = b; sh_refr = r;
    endtask

    // One full sweep; optional mid-sweep load/config writes and extra ticks keyed by neuron slot c.
    task automatic sweep(input bit auto_start, input int ld_at, input int ld_a, input int ld_d,
                         input int cfg_at, input int cth, input int cb, input int cr,
                         input logic [3:0] xtick);
        exp_t e;
        if (!auto_start) tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        ac_th = sh_th; ac_beta = sh_beta; ac_refr = sh_refr;
        m_pending = 0;
        chk("busy_at_start", busy, 1);
        for (int c = 0; c < N; c++) begin
            model_update(c);
            if (xtick[c]) begin
                tick = 1'b1;
                if (m_pending) m_overrun = 1; else m_pending = 1;
            end
            if (ld_at == c) begin
                bus.ld_valid = 1'b1; bus.ld_addr = 2'(ld_a); bus.ld_data = 8'(ld_d);
            end
            if (cfg_at == c) begin
                bus.cfg_we = 1'b1; bus.cfg_thresh = 8'(cth); bus.cfg_beta = 3'(cb); bus.cfg_refr = 4'(cr);
            end
            @(posedge clk); #1;
            tick = 1'b0; bus.ld_valid = 1'b0; bus.cfg_we = 1'b0;
            if (ld_at == c) m_cur[ld_a] = ld_d;
            if (cfg_at == c) begin
                sh_th = cth; sh_beta = cb; sh_refr = cr;
            end
            mon_sel = 2'(c);
            #1;
            e = exp_q.pop_front();
            chk($sformatf("state[%0d]", c), mon_state, e.s);
            chk($sformatf("spike[%0d]", c), spikes[c], e.sp);
            chk("spikes_vec", spikes, m_spk);
            chk($sformatf("done_at_slot%0d", c), done, (c == N - 1) ? 1 : 0);
        end
        @(posedge clk); #1;
        chk("busy_after_done", busy, 0);
        chk("done_cleared", done, 0);
        chk("overrun", overrun, m_overrun);
    endtask

    task automatic plain_sweep();
        sweep(0, -1, 0, 0, -1, 0, 0, 0, 4'b0000);
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_spikes"}, spikes, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_overrun"}, overrun, 0);
        for (int k = 0; k < N; k++) begin
            mon_sel = 2'(k);
            #1;
            chk($sformatf("%s_mon%0d", tag, k), mon_state, 0);
        end
    endtask

    initial begin
        int if_state[6];
        int if_spike[6];
        int ea_spike[3];
        if_state = '{100, 175, 0, 0, 0, 100};
        if_spike = '{0, 0, 1, 0, 0, 0};
        ea_spike = '{1, 0, 1};

        rst_n = 1'b0; tick = 1'b0; mon_sel = '0;
        bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
        bus.cfg_we = 1'b0; bus.cfg_thresh = '0; bus.cfg_beta = '0; bus.cfg_refr = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_idle_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // integrate and fire with default config
        idle_load(0, 100);
        for (int i = 0; i < 6; i++) begin
            plain_sweep();
            mon_sel = 2'd0;
            #1;
            chk($sformatf("if_state_sweep%0d", i + 1), mon_state, if_state[i]);
            chk($sformatf("if_spike_sweep%0d", i + 1), spikes[0], if_spike[i]);
        end

        // reset in the middle of a sweep
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_idle_zero("midreset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        plain_sweep();

        // independent neurons
        idle_cfg(255, 7, 2);
        for (int k = 0; k < N; k++) idle_load(k, 10 * (k + 1));
        plain_sweep();
        for (int k = 0; k < N; k++) begin
            mon_sel = 2'(k);
            #1;
            chk($sformatf("indep_mon%0d", k), mon_state, 10 * (k + 1));
        end

        // tick overlap: one pending tick, then a lost one
        sweep(0, -1, 0, 0, -1, 0, 0, 0, 4'b0001);
        sweep(1, -1, 0, 0, -1, 0, 0, 0, 4'b0000);
        chk("overrun_after_pending", overrun, 0);
        sweep(0, -1, 0, 0, -1, 0, 0, 0, 4'b0011);
        sweep(1, -1, 0, 0, -1, 0, 0, 0, 4'b0000);
        chk("overrun_sticky", overrun, 1);

        // load and config collisions
        do_reset();
        idle_cfg(255, 7, 0);
        sweep(0, 1, 1, 50, -1, 0, 0, 0, 4'b0000);
        mon_sel = 2'd1; #1;
        chk("collide_old_cur", mon_state, 0);
        plain_sweep();
        mon_sel = 2'd1; #1;
        chk("collide_new_cur", mon_state, 50);
        sweep(0, -1, 0, 0, 2, 0, 7, 0, 4'b0000);
        chk("cfg_mid_sweep_no_spike", spikes, 0);
        plain_sweep();
        chk("thresh0_all_spike_a", spikes, 4'hF);
        plain_sweep();
        chk("thresh0_all_spike_b", spikes, 4'hF);

        // beta 0 with full-scale current and threshold
        idle_cfg(255, 0, 1);
        for (int k = 0; k < N; k++) idle_load(k, 255);
        for (int i = 0; i < 3; i++) begin
            plain_sweep();
            chk($sformatf("edge_spike_sweep%0d", i + 1), spikes[0], ea_spike[i]);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
